fb_mem_ctrl: RTL and testbench
==============================

# fb_mem_ctrl

Framebuffer memory controller that time-shares one single-port pixel RAM between the VGA scan-out (read) path and the paint (write) path. It maps 640×480 scan coordinates to a downscaled framebuffer address by a parametrised power-of-two factor. It buffers paint writes in a small FIFO with a ready/valid handshake, and issues each write to the RAM only on cycles the display does not need.

## Interface
Parameters:
- SHIFT, 2, log2 of the downscale factor; read coordinates are shifted right by SHIFT
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- AW, 15, RAM address width; must satisfy 2^AW ≥ FB_W·FB_H
- DW, 3, pixel data width
- DEPTH, 4, write FIFO depth; power of two, ≥ 2

Ports:
- CLK_IN  in  1  pixel clock; single clock domain
- RST_IN  in  1  reset, asynchronous, active-high
- xCoord_a  in  10  display scan x
- yCoord_a  in  10  display scan y
- active  in  1  display is in the visible area
- wr_req  in  1  paint write request (valid)
- xCoord_w  in  8  write x, in framebuffer pixels
- yCoord_w  in  8  write y, in framebuffer pixels
- wr_data  in  DW  write pixel value
- wr_ready  out  1  FIFO can accept a write; combinational, = !full
- mem_addr  out  AW  RAM address, registered
- mem_wen  out  1  RAM write enable, registered
- mem_wdata  out  DW  RAM write data, registered
- rd_strobe  out  1  registered; mem_addr this cycle is a display read
- wr_oob  out  1  sticky flag; an out-of-range write was discarded

## Operation
- Accept a write when wr_req && wr_ready at the clock edge.
  - If xCoord_w ≥ FB_W or yCoord_w ≥ FB_H: set wr_oob and do not push to the FIFO.
  - Otherwise push {FB_W·yCoord_w + xCoord_w, wr_data} to the FIFO. Compute the address at full precision, then truncate to AW.
- Read slot: active && xCoord_a[SHIFT-1:0] == 0.
  - Next cycle: mem_addr = FB_W·(yCoord_a>>SHIFT) + (xCoord_a>>SHIFT), rd_strobe = 1, mem_wen = 0.
  - A read slot always wins over a pending write.
- Write slot: any cycle that is not a read slot and has the FIFO non-empty.
  - Pop the head entry.
  - Next cycle: mem_addr = head address, mem_wdata = head data, mem_wen = 1, rd_strobe = 0.
- Idle: neither slot applies. Next cycle: mem_wen = 0 and rd_strobe = 0; mem_addr and mem_wdata hold their previous values.
- FIFO:
  - Pointers are log2(DEPTH) bits with an extra wrap bit; count ranges 0..DEPTH.
  - Full: count == DEPTH, so wr_ready = 0. No push occurs while full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged and the entry order is preserved.
  - Pop while empty never occurs (write slot requires non-empty).
- Writes leave the FIFO in strict FIFO order. Two writes to the same address both reach the RAM in order.
- wr_oob clears only on reset.
- Reset (asynchronous, any time):
  - mem_addr = 0, mem_wen = 0, mem_wdata = 0, rd_strobe = 0, wr_oob = 0.
  - FIFO empties, so wr_ready = 1.
  - Writes in flight are lost.

## Timing
- Display read latency: coordinates sampled at edge t; mem_addr and rd_strobe valid after edge t+1. RAM read data returns per the RAM's own latency.
- Write latency, minimum: accepted at edge t; entry visible to slot logic during cycle t+1; mem_wen asserted after edge t+2.
- With SHIFT = 2 in the active area: one read slot every 4 pixels, so 3 write slots per 4 clocks. Every blanking cycle is a write slot.
- With SHIFT = 0 and active high: no write slots. The FIFO fills, wr_ready drops, and the FIFO drains at the first blanking cycle.
- mem_wen and rd_strobe are never both 1.

## Test plan
- Reset mid-operation: 3 writes queued with active = 0, assert RST_IN asynchronously between edges.
  - Required: all outputs 0 immediately, wr_ready = 1.
  - Required: no mem_wen after release until new writes arrive.
- Read mapping: active = 1, xCoord_a = 8, yCoord_a = 12.
  - Required next cycle: mem_addr = 482, rd_strobe = 1.
  - Required with xCoord_a = 9: no read slot.
- Single write during blanking: active = 0, write (x=5, y=2, data=3'b101) at edge t.
  - Required: mem_wen = 1, mem_addr = 325, mem_wdata = 101 after edge t+2 only.
- Full and arbitration: active = 1, SHIFT = 0, push DEPTH = 4 writes.
  - Required: wr_ready = 0 after the 4th; a 5th wr_req is ignored.
  - Required: drop active and the 4 writes emerge in order on consecutive cycles.
- Slot interleave: SHIFT = 2, active = 1, xCoord_a counting 0..7, 2 writes queued.
  - Required: mem_wen pulses only on cycles following xCoord_a ∈ {1,2,3,5,6,7}.
  - Required: rd_strobe follows xCoord_a ∈ {0,4}.
- Out of range: write x = 160, y = 0.
  - Required: wr_oob = 1 next cycle, no mem_wen, FIFO count unchanged.

Source files
------------

// File: rtl/fb_mem_ctrl.sv
// Framebuffer memory controller: one single-port pixel RAM shared between
// display scan-out reads and FIFO-buffered paint writes. Reads own every
// read slot; queued writes drain on every other cycle.
module fb_mem_ctrl #(
    parameter int SHIFT = 2,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int AW    = 15,
    parameter int DW    = 3,
    parameter int DEPTH = 4
) (
    input  logic          CLK_IN,
    input  logic          RST_IN,
    input  logic [9:0]    xCoord_a,
    input  logic [9:0]    yCoord_a,
    input  logic          active,
    input  logic          wr_req,
    input  logic [7:0]    xCoord_w,
    input  logic [7:0]    yCoord_w,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic          rd_strobe,
    output logic          wr_oob
);

    localparam int PW = $clog2(DEPTH);
    // Low scan-x bits that must be zero for a pixel to start a new framebuffer column
    localparam logic [9:0] XMASK = 10'((1 << SHIFT) - 1);

    // FIFO storage and pointers (pointers carry an extra wrap bit)
    logic [AW-1:0] fifo_addr_q [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;

    // Registered RAM-side outputs
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_wen_q, mem_wen_d;
    logic          rd_strobe_q, rd_strobe_d;
    logic          wr_oob_q, wr_oob_d;

    logic          full, empty;
    logic          accept, oob, push, pop;
    logic          rd_slot;
    logic [AW-1:0] wr_addr, rd_addr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // Paint side: range check, then address at full precision truncated to AW
    assign oob     = (int'(xCoord_w) >= FB_W) || (int'(yCoord_w) >= FB_H);
    assign accept  = wr_req && !full;
    assign push    = accept && !oob;
    assign wr_addr = AW'(FB_W * int'(yCoord_w) + int'(xCoord_w));

    // Display side: downscaled coordinate mapping and slot detection
    assign rd_slot = active && ((xCoord_a & XMASK) == 10'd0);
    assign rd_addr = AW'(FB_W * int'(yCoord_a >> SHIFT) + int'(xCoord_a >> SHIFT));

    // Slot arbitration: read slot wins, otherwise drain one FIFO entry, otherwise idle
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 1'b0;
        rd_strobe_d = 1'b0;
        pop         = 1'b0;
        if (rd_slot) begin
            mem_addr_d  = rd_addr;
            rd_strobe_d = 1'b1;
        end else if (!empty) begin
            pop         = 1'b1;
            mem_addr_d  = fifo_addr_q[rd_ptr_q[PW-1:0]];
            mem_wdata_d = fifo_data_q[rd_ptr_q[PW-1:0]];
            mem_wen_d   = 1'b1;
        end
    end

    // Pointer advance and sticky out-of-range flag
    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
        wr_oob_d = wr_oob_q | (accept & oob);
    end

    // FIFO entry storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge CLK_IN) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[PW-1:0]] <= wr_addr;
            fifo_data_q[wr_ptr_q[PW-1:0]] <= wr_data;
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_oob_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            rd_strobe_q <= rd_strobe_d;
            wr_oob_q    <= wr_oob_d;
        end
    end

    assign wr_ready  = !full;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_strobe = rd_strobe_q;
    assign wr_oob    = wr_oob_q;

endmodule

// File: tb/tb_fb_mem_ctrl.sv
// Testbench for fb_mem_ctrl: queue-based reference model checked every cycle,
// directed scenarios with hand-computed values, and a randomized phase.
module tb_fb_mem_ctrl;

    localparam int SHIFT = 2;
    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int AW    = 15;
    localparam int DW    = 3;
    localparam int DEPTH = 4;

    logic          CLK_IN = 1'b0;
    logic          RST_IN = 1'b1;
    logic [9:0]    xCoord_a = '0;
    logic [9:0]    yCoord_a = '0;
    logic          active = 1'b0;
    logic          wr_req = 1'b0;
    logic [7:0]    xCoord_w = '0;
    logic [7:0]    yCoord_w = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic          rd_strobe;
    logic          wr_oob;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    fb_mem_ctrl #(
        .SHIFT(SHIFT), .FB_W(FB_W), .FB_H(FB_H), .AW(AW), .DW(DW), .DEPTH(DEPTH)
    ) dut (
        .CLK_IN   (CLK_IN),
        .RST_IN   (RST_IN),
        .xCoord_a (xCoord_a),
        .yCoord_a (yCoord_a),
        .active   (active),
        .wr_req   (wr_req),
        .xCoord_w (xCoord_w),
        .yCoord_w (yCoord_w),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .mem_addr (mem_addr),
        .mem_wen  (mem_wen),
        .mem_wdata(mem_wdata),
        .rd_strobe(rd_strobe),
        .wr_oob   (wr_oob)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int q_addr[$];
    int q_data[$];
    int e_addr, e_wdata, e_wen, e_rd, e_oob;
    int m_div, m_x, m_y;
    bit m_rslot, m_accept;

    always @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            q_addr.delete();
            q_data.delete();
            e_addr = 0; e_wdata = 0; e_wen = 0; e_rd = 0; e_oob = 0;
        end else begin
            m_div    = 1 << SHIFT;
            m_rslot  = active && ((int'(xCoord_a) % m_div) == 0);
            m_accept = wr_req && (q_addr.size() < DEPTH);
            if (m_rslot) begin
                e_addr = (FB_W * (int'(yCoord_a) / m_div) + int'(xCoord_a) / m_div) % (1 << AW);
                e_wen  = 0;
                e_rd   = 1;
            end else if (q_addr.size() > 0) begin
                e_addr  = q_addr.pop_front();
                e_wdata = q_data.pop_front();
                e_wen   = 1;
                e_rd    = 0;
            end else begin
                e_wen = 0;
                e_rd  = 0;
            end
            if (m_accept) begin
                m_x = int'(xCoord_w);
                m_y = int'(yCoord_w);
                if (m_x >= FB_W || m_y >= FB_H) e_oob = 1;
                else begin
                    q_addr.push_back((FB_W * m_y + m_x) % (1 << AW));
                    q_data.push_back(int'(wr_data));
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLK_IN) begin
        if (chk_en) begin
            chk("cyc_addr",  int'(mem_addr),  e_addr);
            chk("cyc_wdata", int'(mem_wdata), e_wdata);
            chk("cyc_wen",   int'(mem_wen),   e_wen);
            chk("cyc_rd",    int'(rd_strobe), e_rd);
            chk("cyc_oob",   int'(wr_oob),    e_oob);
            chk("cyc_ready", int'(wr_ready),  (q_addr.size() < DEPTH) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_addr"},  int'(mem_addr),  0);
        chk({nm, "_wen"},   int'(mem_wen),   0);
        chk({nm, "_wdata"}, int'(mem_wdata), 0);
        chk({nm, "_rd"},    int'(rd_strobe), 0);
        chk({nm, "_oob"},   int'(wr_oob),    0);
        chk({nm, "_ready"}, int'(wr_ready),  1);
    endtask

    int wen_cnt;

    initial begin
        // Reset state
        #1;
        check_all_zero("rst0");
        #11;
        RST_IN = 1'b0;
        chk_en = 1'b1;
        step();

        // Read mapping: (8,12) -> 160*3 + 2 = 482
        active = 1'b1; xCoord_a = 10'd8; yCoord_a = 10'd12;
        step();
        chk("map_addr", int'(mem_addr), 482);
        chk("map_rd", int'(rd_strobe), 1);
        chk("map_wen", int'(mem_wen), 0);
        xCoord_a = 10'd9;
        step();
        chk("map_x9_rd", int'(rd_strobe), 0);
        chk("map_x9_hold", int'(mem_addr), 482);

        // Single write in blanking: (5,2) -> 325, appears after the second edge
        active = 1'b0;
        wr_req = 1'b1; xCoord_w = 8'd5; yCoord_w = 8'd2; wr_data = 3'b101;
        step();
        wr_req = 1'b0;
        chk("sw_wen_early", int'(mem_wen), 0);
        step();
        chk("sw_wen", int'(mem_wen), 1);
        chk("sw_addr", int'(mem_addr), 325);
        chk("sw_data", int'(mem_wdata), 5);
        step();
        chk("sw_wen_after", int'(mem_wen), 0);

        // Full: every cycle is a read slot, so writes pile up
        active = 1'b1; xCoord_a = 10'd0; yCoord_a = 10'd0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_req = 1'b1; xCoord_w = 8'(i); yCoord_w = 8'd1; wr_data = DW'(i);
            step();
        end
        chk("full_ready", int'(wr_ready), 0);
        xCoord_w = 8'd20; wr_data = 3'd7;
        step();
        chk("full_ready2", int'(wr_ready), 0);
        wr_req = 1'b0; active = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("drain_wen", int'(mem_wen), 1);
            chk("drain_addr", int'(mem_addr), 160 + i);
            chk("drain_data", int'(mem_wdata), i);
        end
        step();
        chk("drain_fifth", int'(mem_wen), 0);
        chk("drain_ready", int'(wr_ready), 1);

        // Slot interleave with two writes queued during read slots
        active = 1'b1; xCoord_a = 10'd0; yCoord_a = 10'd4;
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1; xCoord_w = 8'(1 + i); yCoord_w = 8'd3; wr_data = DW'(2 + i);
            step();
        end
        wr_req = 1'b0;
        wen_cnt = 0;
        for (int x = 0; x < 8; x++) begin
            xCoord_a = 10'(x);
            step();
            chk("ilv_rd", int'(rd_strobe), (x % 4 == 0) ? 1 : 0);
            chk("ilv_wen_slot", int'(mem_wen && (x % 4 == 0)), 0);
            if (mem_wen) wen_cnt++;
        end
        chk("ilv_wen_count", wen_cnt, 2);

        // Out-of-range write is discarded and flagged
        active = 1'b0;
        chk("oob_pre", int'(wr_oob), 0);
        wr_req = 1'b1; xCoord_w = 8'd160; yCoord_w = 8'd0; wr_data = 3'd1;
        step();
        wr_req = 1'b0;
        chk("oob_flag", int'(wr_oob), 1);
        chk("oob_ready", int'(wr_ready), 1);
        step();
        chk("oob_nowen", int'(mem_wen), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            active   = ($urandom_range(0, 9) < 7);
            xCoord_a = 10'($urandom_range(0, 639));
            yCoord_a = 10'($urandom_range(0, 479));
            wr_req   = $urandom_range(0, 1) == 1;
            xCoord_w = 8'($urandom_range(0, 170));
            yCoord_w = 8'($urandom_range(0, 125));
            wr_data  = DW'($urandom);
            step();
        end

        // Reset mid-operation with three writes queued
        active = 1'b1; xCoord_a = 10'd0; yCoord_a = 10'd0;
        wr_req = 1'b0;
        repeat (DEPTH + 1) step();
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; xCoord_w = 8'(10 + i); yCoord_w = 8'd7; wr_data = DW'(i);
            step();
        end
        wr_req = 1'b0; active = 1'b0;
        #2;
        RST_IN = 1'b1;
        #1;
        check_all_zero("amid");
        step();
        #2;
        RST_IN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_nowen", int'(mem_wen), 0);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
